// File: rtl/irq_sequencer.sv
// ---------------------------------------------------------------------------
// irq_sequencer
//
// Purpose:
//   Interrupt front-end for the MCU core.
//   - Latches rising edges on NUM_SRC peripheral request lines into a
//     pending register.
//   - Gates pending requests with a per-source enable mask.
//   - Picks the highest-priority request; index 0 is the highest priority.
//   - Waits for an instruction boundary with the global machine interrupt
//     enable set, then issues a one-cycle int_taken pulse to the CSR file.
//   - Tracks handler occupancy until mret. Nesting is not supported.
//
// Parameters:
//   NUM_SRC  number of interrupt sources (1..16)
//   CAUSE_W  width of irq_cause; 2**CAUSE_W >= NUM_SRC
//
// Ports:
//   clk             system clock, rising-edge active
//   rst             synchronous active-low reset (0 = reset)
//   irq_src         level request lines; a rising edge raises a request
//   mask_w_en       write strobe for the enable mask
//   mask_w_data     new mask value, 1 = source enabled
//   csr_mie         global interrupt enable from the CSR file
//   instr_boundary  core can accept a trap this cycle
//   mret            one-cycle pulse when the core retires mret
//   int_taken       one-cycle trap pulse to the CSR file
//   irq_cause       index of the serviced source, latched at trap entry
//   in_handler      high while a handler is running
//   pending         current pending register
//   mask            current mask register
//
// Optional feature (macro IRQ_SYNC_EN):
//   When IRQ_SYNC_EN is defined, irq_src passes through a 2-flop
//   synchronizer before edge detection. This adds two cycles of
//   request-to-trap latency.
//   When IRQ_SYNC_EN is not defined, irq_src must already be synchronous
//   to clk.
// ---------------------------------------------------------------------------
module irq_sequencer #(
  parameter int NUM_SRC = 4,
  parameter int CAUSE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               mask_w_en,
  input  logic [NUM_SRC-1:0] mask_w_data,
  input  logic               csr_mie,
  input  logic               instr_boundary,
  input  logic               mret,
  output logic               int_taken,
  output logic [CAUSE_W-1:0] irq_cause,
  output logic               in_handler,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] mask
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TAKE    = 2'd1,
    HANDLER = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [NUM_SRC-1:0] src_in;
  logic [NUM_SRC-1:0] hist;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] clr;
  logic [NUM_SRC-1:0] active;
  logic [CAUSE_W-1:0] sel;
  logic               any_req;
  logic               take_go;

  // -------------------------------------------------------------------------
  // Source conditioning
  // -------------------------------------------------------------------------
`ifdef IRQ_SYNC_EN
  logic [NUM_SRC-1:0] sync_q1;
  logic [NUM_SRC-1:0] sync_q2;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= irq_src;
      sync_q2 <= sync_q1;
    end
  end

  assign src_in = sync_q2;
`else
  assign src_in = irq_src;
`endif

  // -------------------------------------------------------------------------
  // Edge detection
  // The history register holds the conditioned source value from the
  // previous cycle.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      hist <= '0;
    end else begin
      hist <= src_in;
    end
  end

  assign rise = src_in & ~hist;

  // -------------------------------------------------------------------------
  // Claim vector
  // clr is one-hot on the latched cause and is asserted only during TAKE.
  // Comparing against each index avoids indexing past NUM_SRC when
  // CAUSE_W is wider than needed.
  // -------------------------------------------------------------------------
  always_comb begin
    clr = '0;
    if (state == TAKE) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        clr[i] = (irq_cause == CAUSE_W'(i));
      end
    end
  end

  // -------------------------------------------------------------------------
  // Pending register
  // The new rise is ORed in after the claim clears the bit. A request that
  // re-arms in the TAKE cycle is therefore kept, not lost.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr) | rise;
    end
  end

  // -------------------------------------------------------------------------
  // Mask register
  // The mask only gates selection; masked sources still latch into pending.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      mask <= '0;
    end else if (mask_w_en) begin
      mask <= mask_w_data;
    end
  end

  // -------------------------------------------------------------------------
  // Priority selection
  // The loop scans from high index to low, so the lowest set index is the
  // last one assigned and wins.
  // -------------------------------------------------------------------------
  assign active  = pending & mask;
  assign any_req = |active;

  always_comb begin
    sel = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active[i]) begin
        sel = CAUSE_W'(i);
      end
    end
  end

  assign take_go = (state == IDLE) && any_req && csr_mie && instr_boundary;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // HANDLER ignores new requests. Leaving on mret always goes through IDLE,
  // so the earliest follow-up trap is two cycles after mret.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (take_go) begin
          state_next = TAKE;
        end
      end
      TAKE: begin
        state_next = HANDLER;
      end
      HANDLER: begin
        if (mret) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    int_taken  = 1'b0;
    in_handler = 1'b0;
    case (state)
      TAKE:    int_taken  = 1'b1;
      HANDLER: in_handler = 1'b1;
      default: begin
        int_taken  = 1'b0;
        in_handler = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Cause register
  // The cause is captured on the IDLE->TAKE decision, so it is valid during
  // the int_taken pulse. It is held through the handler and only reset
  // clears it.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      irq_cause <= '0;
    end else if (take_go) begin
      irq_cause <= sel;
    end
  end

endmodule

// File: tb/tb_irq_sequencer.sv
// ---------------------------------------------------------------------------
// tb_irq_sequencer
//
// Self-checking bench for irq_sequencer with NUM_SRC = 4.
// Expected traps (cause and cycle) are pushed to a scoreboard queue when
// the stimulus is driven. A negedge monitor pops one entry per int_taken
// pulse and compares it with the DUT.
// ---------------------------------------------------------------------------
module tb_irq_sequencer;

  localparam int NUM_SRC = 4;
  localparam int CAUSE_W = 4;
`ifdef IRQ_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic               clk;
  logic               rst;
  logic [NUM_SRC-1:0] irq_src;
  logic               mask_w_en;
  logic [NUM_SRC-1:0] mask_w_data;
  logic               csr_mie;
  logic               instr_boundary;
  logic               mret;
  logic               int_taken;
  logic [CAUSE_W-1:0] irq_cause;
  logic               in_handler;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] mask;

  typedef struct {
    int cause;
    int cycle;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  irq_sequencer #(.NUM_SRC(NUM_SRC), .CAUSE_W(CAUSE_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .irq_src       (irq_src),
    .mask_w_en     (mask_w_en),
    .mask_w_data   (mask_w_data),
    .csr_mie       (csr_mie),
    .instr_boundary(instr_boundary),
    .mret          (mret),
    .int_taken     (int_taken),
    .irq_cause     (irq_cause),
    .in_handler    (in_handler),
    .pending       (pending),
    .mask          (mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  // Scoreboard monitor: every trap pulse must match the next expected entry.
  always @(negedge clk) begin
    if (rst && int_taken) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_take", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("take_cause", 32'(irq_cause), 32'(e.cause));
        checkOutput("take_cycle", 32'(cyc), 32'(e.cycle));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [NUM_SRC-1:0] src, input logic mie, input logic ib);
    irq_src        = src;
    csr_mie        = mie;
    instr_boundary = ib;
  endtask

  task automatic write_mask(input logic [NUM_SRC-1:0] m);
    mask_w_en   = 1'b1;
    mask_w_data = m;
    tick();
    mask_w_en   = 1'b0;
  endtask

  task automatic pulse_mret();
    mret = 1'b1;
    tick();
    mret = 1'b0;
  endtask

  task automatic expect_take(input int cause, input int at_cycle);
    exp_t e;
    e.cause = cause;
    e.cycle = at_cycle;
    exp_q.push_back(e);
  endtask

  initial begin
    rst         = 1'b0;
    mask_w_en   = 1'b0;
    mask_w_data = '0;
    mret        = 1'b0;
    applyStimulus(4'b0000, 1'b0, 1'b0);

    // Reset state
    tick();
    tick();
    checkOutput("rst_int_taken", 32'(int_taken), 32'd0);
    checkOutput("rst_irq_cause", 32'(irq_cause), 32'd0);
    checkOutput("rst_in_handler", 32'(in_handler), 32'd0);
    checkOutput("rst_pending", 32'(pending), 32'd0);
    checkOutput("rst_mask", 32'(mask), 32'd0);
    rst = 1'b1;
    write_mask(4'b1111);
    checkOutput("mask_write", 32'(mask), 32'hf);
    applyStimulus(4'b0000, 1'b1, 1'b1);
    tick();

    // Single source 2
    expect_take(2, cyc + LAT);
    applyStimulus(4'b0100, 1'b1, 1'b1);
    for (int i = 0; i < LAT; i++) tick();
    checkOutput("t1_in_handler_take", 32'(in_handler), 32'd0);
    tick();
    checkOutput("t1_in_handler", 32'(in_handler), 32'd1);
    checkOutput("t1_pending", 32'(pending), 32'd0);
    checkOutput("t1_cause_hold", 32'(irq_cause), 32'd2);
    checkOutput("t1_no_pulse", 32'(int_taken), 32'd0);
    applyStimulus(4'b0000, 1'b1, 1'b1);
    pulse_mret();
    checkOutput("t1_idle", 32'(in_handler), 32'd0);
    tick();

    // Priority: sources 3 and 1 together
    expect_take(1, cyc + LAT);
    applyStimulus(4'b1010, 1'b1, 1'b1);
    for (int i = 0; i < LAT; i++) tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("t2_pending3_held", 32'(pending), 32'h8);
      checkOutput("t2_in_handler", 32'(in_handler), 32'd1);
    end
    applyStimulus(4'b0000, 1'b1, 1'b1);
    expect_take(3, cyc + 2);
    pulse_mret();
    checkOutput("t2_idle_after_mret", 32'(in_handler), 32'd0);
    tick();
    tick();
    checkOutput("t2_second_cause", 32'(irq_cause), 32'd3);
    checkOutput("t2_pending_clear", 32'(pending), 32'd0);
    pulse_mret();
    tick();

    // Gating by csr_mie and instr_boundary
    applyStimulus(4'b0000, 1'b0, 1'b1);
    tick();
    applyStimulus(4'b0001, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) tick();
    checkOutput("t3_pending_mie0", 32'(pending), 32'h1);
    checkOutput("t3_no_take_mie0", 32'(int_taken), 32'd0);
    applyStimulus(4'b0001, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    checkOutput("t3_no_take_ib0", 32'(int_taken), 32'd0);
    checkOutput("t3_pending_ib0", 32'(pending), 32'h1);
    expect_take(0, cyc + 1);
    applyStimulus(4'b0000, 1'b1, 1'b1);
    tick();
    tick();
    checkOutput("t3_handler", 32'(in_handler), 32'd1);
    pulse_mret();
    tick();

    // Masking
    write_mask(4'b0000);
    applyStimulus(4'b0010, 1'b1, 1'b1);
    for (int i = 0; i < LAT + 2; i++) tick();
    checkOutput("t4_pending_masked", 32'(pending), 32'h2);
    checkOutput("t4_no_take", 32'(int_taken), 32'd0);
    checkOutput("t4_not_in_handler", 32'(in_handler), 32'd0);
    expect_take(1, cyc + 2);
    write_mask(4'b0010);
    tick();
    tick();
    checkOutput("t4_handler", 32'(in_handler), 32'd1);
    applyStimulus(4'b0000, 1'b1, 1'b1);
    pulse_mret();
    write_mask(4'b1111);
    tick();

    // Same-cycle set and clear on source 0
    expect_take(0, cyc + LAT);
    applyStimulus(4'b0001, 1'b1, 1'b1);
    tick();
    applyStimulus(4'b0000, 1'b1, 1'b1);
    tick();
    applyStimulus(4'b0001, 1'b1, 1'b1);
    for (int i = 0; i < LAT - 2; i++) tick();
    tick();
    checkOutput("t5_pending_rearmed", 32'(pending), 32'h1);
    checkOutput("t5_handler", 32'(in_handler), 32'd1);
    expect_take(0, cyc + 2);
    pulse_mret();
    tick();
    tick();
    checkOutput("t5_second_handler", 32'(in_handler), 32'd1);
    checkOutput("t5_pending_after", 32'(pending), 32'd0);
    applyStimulus(4'b0000, 1'b1, 1'b1);
    pulse_mret();
    tick();

    // Reset in the middle of a handler
    expect_take(2, cyc + LAT);
    applyStimulus(4'b0100, 1'b1, 1'b1);
    tick();
    applyStimulus(4'b0000, 1'b1, 1'b1);
    for (int i = 0; i < LAT - 1; i++) tick();
    tick();
    checkOutput("t6_in_handler_pre", 32'(in_handler), 32'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checkOutput("t6_in_handler", 32'(in_handler), 32'd0);
    checkOutput("t6_irq_cause", 32'(irq_cause), 32'd0);
    checkOutput("t6_pending", 32'(pending), 32'd0);
    checkOutput("t6_mask", 32'(mask), 32'd0);
    for (int i = 0; i < 5; i++) tick();
    checkOutput("t6_no_take", 32'(int_taken), 32'd0);
    applyStimulus(4'b1000, 1'b1, 1'b1);
    for (int i = 0; i < LAT + 2; i++) tick();
    checkOutput("t6_pending_new", 32'(pending), 32'h8);
    expect_take(3, cyc + 2);
    write_mask(4'b1111);
    tick();
    tick();
    checkOutput("t6_handler_again", 32'(in_handler), 32'd1);
    applyStimulus(4'b0000, 1'b1, 1'b1);
    pulse_mret();

    for (int i = 0; i < 5; i++) tick();
    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
